// File: rtl/rfwa_pkg.sv
// Shared types for the register-file write-back arbiter.
// RFWA_BYPASS_EN enables write-to-read forwarding in the top.
package rfwa_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] idx;
        logic [XLEN_DEF-1:0]  data;
    } wb_port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio names the side that wins a tie.
// Grants are suppressed and prio frozen while en is low.
module rr_arb2
    import rfwa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    wb_src_e prio_q;
    wb_src_e prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio_q == WB_MEM) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        // The side that just lost (or did not ask) wins the next tie
        if (gnt[WB_ALU]) begin
            prio_d = WB_MEM;
        end else if (gnt[WB_MEM]) begin
            prio_d = WB_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= WB_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load return.
// Define RFWA_BYPASS_EN to forward the committing write to the read ports.
module regfile_wb_arbiter
    import rfwa_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    input  logic                 hold,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      writeData,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    output logic [XLEN-1:0]      fwd_data1,
    output logic [XLEN-1:0]      fwd_data2,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic [1:0]           gnt;
    logic                 we_q, we_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({mem_valid, alu_valid}),
        .en    (!hold),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[WB_ALU];
    assign mem_ready = gnt[WB_MEM];

    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        // x0 requests are consumed but never raise the write enable
        unique case (1'b1)
            gnt[WB_ALU]: begin
                we_d   = (alu_rd != '0);
                rd_d   = alu_rd;
                data_d = alu_data;
            end
            gnt[WB_MEM]: begin
                we_d   = (mem_rd != '0);
                rd_d   = mem_rd;
                data_d = mem_data;
            end
            default: ;
        endcase
        if (alu_valid && mem_valid && !hold && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign RegWrite     = we_q;
    assign rd           = rd_q;
    assign writeData    = data_q;
    assign conflict_cnt = cnt_q;

`ifdef RFWA_BYPASS_EN
    assign fwd_data1 = (we_q && rd_q == rs1 && rs1 != '0) ? data_q : rf_rdata1;
    assign fwd_data2 = (we_q && rd_q == rs2 && rs2 != '0) ? data_q : rf_rdata2;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd_data1 = rf_rdata1;
    assign fwd_data2 = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter with a register-file model.
// Build with +define+RFWA_BYPASS_EN to check the forwarding variant.
module tb_regfile_wb_arbiter;
    import rfwa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0, rs1 = '0, rs2 = '0;
    logic [63:0] alu_data = '0, mem_data = '0, rf_rdata1 = '0, rf_rdata2 = '0;
    logic        alu_ready, mem_ready, RegWrite;
    logic [4:0]  rd;
    logic [63:0] writeData, fwd_data1, fwd_data2;
    logic [15:0] conflict_cnt;
    logic        alu_ready2, mem_ready2, RegWrite2;
    logic [4:0]  rd2;
    logic [63:0] writeData2, fwd2_1, fwd2_2;
    logic [1:0]  conflict_cnt2;

    regfile_wb_arbiter #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .hold(hold), .RegWrite(RegWrite), .rd(rd), .writeData(writeData),
        .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.XLEN(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready2),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready2),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .hold(hold), .RegWrite(RegWrite2), .rd(rd2), .writeData(writeData2),
        .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_data1(fwd2_1), .fwd_data2(fwd2_2),
        .conflict_cnt(conflict_cnt2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference state: architectural view, not the RTL's registers
    logic [63:0] rf [32];
    wb_port_t    cur;
    int          cnt;
    bit          alu_turn;
    bit          a_pend, m_pend;
    logic [4:0]  a_rd, m_rd;
    logic [63:0] a_dat, m_dat;
    wb_port_t    sb [$];

    task automatic model_reset();
        foreach (rf[i]) rf[i] = '0;
        cur = '0;
        cnt = 0;
        alu_turn = 1'b1;
        sb.delete();
    endtask

    function automatic logic [63:0] exp_fwd(input logic [4:0] rs);
`ifdef RFWA_BYPASS_EN
        if (cur.we && cur.idx == rs && rs != 0) return cur.data;
`endif
        return rf[rs];
    endfunction

    // Monitor: one expected write-port image per cycle
    always @(negedge clk) begin
        wb_port_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            chk("RegWrite", {63'd0, RegWrite}, {63'd0, e.we});
            chk("rd", {59'd0, rd}, {59'd0, e.idx});
            chk("writeData", writeData, e.data);
            chk("dut2_RegWrite", {63'd0, RegWrite2}, {63'd0, e.we});
        end
    end

    task automatic cycle(input int pv, input int ph, input bit quiet);
        bit ga, gm;
        wb_port_t nxt;
        @(negedge clk);
        if (!a_pend && $urandom_range(0, 99) < pv) begin
            a_pend = 1'b1;
            a_rd   = 5'($urandom_range(0, 7));
            a_dat  = {$urandom, $urandom};
        end
        if (!m_pend && $urandom_range(0, 99) < pv) begin
            m_pend = 1'b1;
            m_rd   = 5'($urandom_range(0, 7));
            m_dat  = {$urandom, $urandom};
        end
        alu_valid = a_pend && !quiet;
        mem_valid = m_pend && !quiet;
        alu_rd    = a_rd;
        alu_data  = a_dat;
        mem_rd    = m_rd;
        mem_data  = m_dat;
        hold      = ($urandom_range(0, 99) < ph);
        rs1       = 5'($urandom_range(0, 7));
        rs2       = 5'($urandom_range(0, 7));
        rf_rdata1 = rf[rs1];
        rf_rdata2 = rf[rs2];
        #1;
        ga = alu_valid && !hold && (!mem_valid || alu_turn);
        gm = mem_valid && !hold && !ga;
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
        chk("mem_ready", {63'd0, mem_ready}, {63'd0, gm});
        chk("fwd_data1", fwd_data1, exp_fwd(rs1));
        chk("fwd_data2", fwd_data2, exp_fwd(rs2));
        chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(cnt));
        chk("conflict_cnt_sat", {62'd0, conflict_cnt2}, 64'(cnt > 3 ? 3 : cnt));
        nxt = cur;
        nxt.we = 1'b0;
        if (ga) nxt = '{we: a_rd != 0, idx: a_rd, data: a_dat};
        if (gm) nxt = '{we: m_rd != 0, idx: m_rd, data: m_dat};
        sb.push_back(nxt);
        @(posedge clk);
        if (cur.we) rf[cur.idx] = cur.data;
        cur = nxt;
        if (ga) begin a_pend = 1'b0; alu_turn = 1'b0; end
        if (gm) begin m_pend = 1'b0; alu_turn = 1'b1; end
        if (alu_valid && mem_valid && !hold) cnt++;
    endtask

    initial begin
        model_reset();
        a_pend = 0; m_pend = 0;
        a_rd = '0; m_rd = '0; a_dat = '0; m_dat = '0;
        #3;
        chk("reset_RegWrite", {63'd0, RegWrite}, 64'd0);
        chk("reset_rd", {59'd0, rd}, 64'd0);
        chk("reset_writeData", writeData, 64'd0);
        chk("reset_cnt", {48'd0, conflict_cnt}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 150; i++) cycle(100, 0, 0);
        for (int i = 0; i < 150; i++) cycle(60, 40, 0);
        for (int i = 0; i < 150; i++) cycle(30, 10, 0);
        cycle(0, 0, 1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_RegWrite", {63'd0, RegWrite}, 64'd0);
        chk("async_rd", {59'd0, rd}, 64'd0);
        chk("async_writeData", writeData, 64'd0);
        chk("async_cnt", {48'd0, conflict_cnt}, 64'd0);
        chk("async_cnt2", {62'd0, conflict_cnt2}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 150; i++) cycle(80, 20, 0);
        cycle(0, 0, 1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
